// File: rtl/err_inj_pkg.sv
// Shared types and default sizing for the error-injection hierarchy.
// The splitter tree instantiations use the same constants so the target
// count seen by the sequencer always matches what the tree can decode.
package err_inj_pkg;

    localparam int ERR_INW     = 5;
    localparam int ERR_NUM_TGT = 25;
    localparam int ERR_CNTW    = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DELAY,
        ST_INJECT,
        ST_GAP,
        ST_DONE
    } err_inj_state_e;

    // Latched copy of an accepted command. Field widths follow the package
    // defaults; the sequencer parameters are expected to track them.
    typedef struct packed {
        logic                sweep;
        logic [ERR_INW-1:0]  target;
        logic [ERR_INW-1:0]  last;
        logic [ERR_CNTW-1:0] delay;
        logic [ERR_CNTW-1:0] len;
        logic [ERR_CNTW-1:0] gap;
    } err_cmd_t;

endpackage

// File: rtl/err_inj_cnt.sv
// Loadable down-counter shared by the delay, inject and gap phases.
// term flags the last cycle of a phase (count == 1); the counter parks at 0
// instead of wrapping.
module err_inj_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         term
);

    logic [W-1:0] cnt;

    // Load has priority so a phase change can restart the count in the same
    // cycle the previous phase terminates.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign term = (cnt == W'(1));

endmodule

// File: rtl/err_inj_sequencer.sv
// Top of the error-injection hierarchy: accepts one command per handshake and
// plays it out on err_en/err_ctrl toward the root splitter, optionally
// sweeping a contiguous target range with gaps between windows.
module err_inj_sequencer
    import err_inj_pkg::*;
#(
    parameter int INW     = ERR_INW,
    parameter int NUM_TGT = ERR_NUM_TGT,
    parameter int CNTW    = ERR_CNTW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_sweep,
    input  logic [INW-1:0]  cmd_target,
    input  logic [INW-1:0]  cmd_last,
    input  logic [CNTW-1:0] cmd_delay,
    input  logic [CNTW-1:0] cmd_len,
    input  logic [CNTW-1:0] cmd_gap,
    input  logic            abort,
    output logic            err_en,
    output logic [INW-1:0]  err_ctrl,
    output logic            busy,
    output logic            done,
    output logic            cmd_err
);

    localparam logic [INW:0] TGT_LIM = (INW+1)'(NUM_TGT);

    err_inj_state_e  state, state_nxt;
    err_cmd_t        cmd_q, cmd_nxt;
    logic [INW-1:0]  tgt_q, tgt_nxt;
    logic            cnt_load;
    logic [CNTW-1:0] cnt_val;
    logic            cnt_en;
    logic            cnt_term;
    logic            accept;
    logic            bad_cmd;
    logic            reject;

    assign accept = cmd_valid & cmd_ready;

    // Command validity is judged on the live inputs at the accept edge.
    assign bad_cmd = (cmd_len == '0)
                   || ({1'b0, cmd_target} >= TGT_LIM)
                   || (cmd_sweep && (({1'b0, cmd_last} >= TGT_LIM)
                                     || (cmd_last < cmd_target)));

    err_inj_cnt #(.W(CNTW)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .en       (cnt_en),
        .term     (cnt_term)
    );

    // State, latched command and current target.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cmd_q <= '0;
            tgt_q <= '0;
        end else begin
            state <= state_nxt;
            cmd_q <= cmd_nxt;
            tgt_q <= tgt_nxt;
        end
    end

    // Next-state, counter control and target stepping.
    always_comb begin
        state_nxt = state;
        cmd_nxt   = cmd_q;
        tgt_nxt   = tgt_q;
        cnt_load  = 1'b0;
        cnt_val   = '0;
        cnt_en    = 1'b0;
        reject    = 1'b0;
        unique case (state)
            // DONE behaves like IDLE; abort has no effect here.
            ST_IDLE, ST_DONE: begin
                state_nxt = ST_IDLE;
                if (accept) begin
                    if (bad_cmd) begin
                        reject = 1'b1;
                    end else begin
                        cmd_nxt.sweep  = cmd_sweep;
                        cmd_nxt.target = cmd_target;
                        cmd_nxt.last   = cmd_last;
                        cmd_nxt.delay  = cmd_delay;
                        cmd_nxt.len    = cmd_len;
                        cmd_nxt.gap    = cmd_gap;
                        tgt_nxt        = cmd_target;
                        cnt_load       = 1'b1;
                        if (cmd_delay != '0) begin
                            state_nxt = ST_DELAY;
                            cnt_val   = cmd_delay;
                        end else begin
                            state_nxt = ST_INJECT;
                            cnt_val   = cmd_len;
                        end
                    end
                end
            end
            ST_DELAY: begin
                cnt_en = 1'b1;
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (cnt_term) begin
                    state_nxt = ST_INJECT;
                    cnt_load  = 1'b1;
                    cnt_val   = cmd_q.len;
                end
            end
            ST_INJECT: begin
                cnt_en = 1'b1;
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (cnt_term) begin
                    if (!cmd_q.sweep || tgt_q == cmd_q.last) begin
                        state_nxt = ST_DONE;
                    end else if (cmd_q.gap != '0) begin
                        state_nxt = ST_GAP;
                        cnt_load  = 1'b1;
                        cnt_val   = cmd_q.gap;
                    end else begin
                        // Back-to-back windows: err_en stays high, target steps.
                        state_nxt = ST_INJECT;
                        cnt_load  = 1'b1;
                        cnt_val   = cmd_q.len;
                        tgt_nxt   = tgt_q + INW'(1);
                    end
                end
            end
            ST_GAP: begin
                cnt_en = 1'b1;
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (cnt_term) begin
                    state_nxt = ST_INJECT;
                    cnt_load  = 1'b1;
                    cnt_val   = cmd_q.len;
                    tgt_nxt   = tgt_q + INW'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_en    <= 1'b0;
            err_ctrl  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cmd_err   <= 1'b0;
            cmd_ready <= 1'b1;
        end else begin
            err_en    <= (state_nxt == ST_INJECT);
            err_ctrl  <= (state_nxt == ST_INJECT) ? tgt_nxt : '0;
            busy      <= (state_nxt == ST_DELAY) || (state_nxt == ST_INJECT)
                      || (state_nxt == ST_GAP);
            done      <= (state_nxt == ST_DONE);
            cmd_err   <= reject;
            cmd_ready <= (state_nxt == ST_IDLE) || (state_nxt == ST_DONE);
        end
    end

endmodule

// File: tb/tb_err_inj_sequencer.sv
// Directed bench for err_inj_sequencer; cycle numbers count edges after the
// accept edge, outputs sampled 1ns after each rising edge.
module tb_err_inj_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_sweep;
    logic [4:0]  cmd_target, cmd_last;
    logic [15:0] cmd_delay, cmd_len, cmd_gap;
    logic        abort, err_en, busy, done, cmd_err;
    logic [4:0]  err_ctrl;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    err_inj_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_sweep  (cmd_sweep),
        .cmd_target (cmd_target),
        .cmd_last   (cmd_last),
        .cmd_delay  (cmd_delay),
        .cmd_len    (cmd_len),
        .cmd_gap    (cmd_gap),
        .abort      (abort),
        .err_en     (err_en),
        .err_ctrl   (err_ctrl),
        .busy       (busy),
        .done       (done),
        .cmd_err    (cmd_err)
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_cyc(input string tag, input int en, input int ctrl,
                           input int bsy, input int dn);
        chk({tag, ".err_en"},   int'(err_en),   en);
        chk({tag, ".err_ctrl"}, int'(err_ctrl), ctrl);
        chk({tag, ".busy"},     int'(busy),     bsy);
        chk({tag, ".done"},     int'(done),     dn);
    endtask

    task automatic exp_reset(input string tag);
        exp_cyc(tag, 0, 0, 0, 0);
        chk({tag, ".cmd_err"},   int'(cmd_err),   0);
        chk({tag, ".cmd_ready"}, int'(cmd_ready), 1);
    endtask

    task automatic set_cmd(input logic sw, input int tgt, input int lst,
                           input int dly, input int len, input int gap);
        cmd_sweep  = sw;
        cmd_target = 5'(tgt);
        cmd_last   = 5'(lst);
        cmd_delay  = 16'(dly);
        cmd_len    = 16'(len);
        cmd_gap    = 16'(gap);
    endtask

    // Present a command, take the accept edge, then drop cmd_valid (cycle 1).
    task automatic send(input logic sw, input int tgt, input int lst,
                        input int dly, input int len, input int gap);
        set_cmd(sw, tgt, lst, dly, len, gap);
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
    endtask

    initial begin
        int en;
        rst = 1'b1; cmd_valid = 1'b0; abort = 1'b0;
        set_cmd(0, 0, 0, 0, 0, 0);
        step(); step();
        exp_reset("reset");
        rst = 1'b0;
        step();

        // Single: target 7, delay 3, len 2.
        send(0, 7, 0, 3, 2, 0);
        for (int c = 1; c <= 6; c++) begin
            if (c > 1) step();
            en = (c >= 4 && c <= 5) ? 1 : 0;
            exp_cyc($sformatf("single.c%0d", c), en, en ? 7 : 0,
                    (c <= 5) ? 1 : 0, (c == 6) ? 1 : 0);
        end
        chk("single.ready_done", int'(cmd_ready), 1);
        step();

        // Sweep 5..7, len 1, gap 1.
        send(1, 5, 7, 0, 1, 1);
        for (int c = 1; c <= 6; c++) begin
            if (c > 1) step();
            en = (c <= 5 && (c % 2) == 1) ? 1 : 0;
            exp_cyc($sformatf("sweep_g1.c%0d", c), en, en ? 5 + (c - 1) / 2 : 0,
                    (c <= 5) ? 1 : 0, (c == 6) ? 1 : 0);
        end
        step();

        // Sweep 5..7, len 1, gap 0: back-to-back windows.
        send(1, 5, 7, 0, 1, 0);
        for (int c = 1; c <= 4; c++) begin
            if (c > 1) step();
            en = (c <= 3) ? 1 : 0;
            exp_cyc($sformatf("sweep_g0.c%0d", c), en, en ? 4 + c : 0,
                    en, (c == 4) ? 1 : 0);
        end
        step();

        // Rejects: target out of range, zero length, reversed sweep.
        for (int r = 0; r < 3; r++) begin
            case (r)
                0:       send(0, 25, 0, 0, 3, 0);
                1:       send(0, 2, 0, 1, 0, 0);
                default: send(1, 4, 3, 0, 2, 0);
            endcase
            chk($sformatf("rej%0d.cmd_err", r),   int'(cmd_err),   1);
            chk($sformatf("rej%0d.ready", r),     int'(cmd_ready), 1);
            chk($sformatf("rej%0d.err_en", r),    int'(err_en),    0);
            chk($sformatf("rej%0d.busy", r),      int'(busy),      0);
            step();
            chk($sformatf("rej%0d.cmd_err2", r),  int'(cmd_err),   0);
            chk($sformatf("rej%0d.err_en2", r),   int'(err_en),    0);
        end

        // Abort during INJECT, then a new command (with abort still high) in
        // the first idle cycle.
        send(0, 10, 0, 0, 8, 0);
        step(); step();
        exp_cyc("abort.c3", 1, 10, 1, 0);
        abort = 1'b1;
        step();
        exp_cyc("abort.c4", 0, 0, 0, 0);
        chk("abort.ready", int'(cmd_ready), 1);
        send(0, 2, 0, 0, 1, 0);
        abort = 1'b0;
        exp_cyc("abort_new.c1", 1, 2, 1, 0);
        step();
        exp_cyc("abort_new.c2", 0, 0, 0, 1);
        step();

        // cmd_valid held with different fields during a run: ignored until
        // the done cycle, where it is accepted.
        send(0, 3, 0, 1, 2, 0);
        set_cmd(0, 9, 0, 2, 1, 0);
        cmd_valid = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            if (c > 1) step();
            en = (c >= 2 && c <= 3) ? 1 : 0;
            exp_cyc($sformatf("hold.c%0d", c), en, en ? 3 : 0,
                    (c <= 3) ? 1 : 0, (c == 4) ? 1 : 0);
        end
        step();
        cmd_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            if (c > 1) step();
            en = (c == 3) ? 1 : 0;
            exp_cyc($sformatf("hold2.c%0d", c), en, en ? 9 : 0,
                    (c <= 3) ? 1 : 0, (c == 4) ? 1 : 0);
        end
        step();

        // Reset mid-DELAY.
        send(0, 1, 0, 5, 1, 0);
        step();
        chk("rst_dly.busy_pre", int'(busy), 1);
        rst = 1'b1;
        step();
        exp_reset("rst_dly");
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step();
            exp_reset($sformatf("rst_dly.after%0d", c));
        end

        // Reset mid-GAP.
        send(1, 1, 3, 0, 1, 3);
        exp_cyc("rst_gap.c1", 1, 1, 1, 0);
        step(); step();
        exp_cyc("rst_gap.c3", 0, 0, 1, 0);
        rst = 1'b1;
        step();
        exp_reset("rst_gap");
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step();
            exp_reset($sformatf("rst_gap.after%0d", c));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/err_inj_sequencer.md
Name: err_inj_sequencer

Overview:
- Drives the top-level `err_en` / `err_ctrl` pair consumed by the error-control splitter tree, which decodes it into local and submodule injection enables.
- Accepts one injection command per handshake, then runs it cycle-accurately: optional start delay, injection window, and optionally a sweep across a contiguous target range with gaps between windows.
- Sits at the top of the error-injection hierarchy, between the host/control interface and the root splitter.

Parameters:
- INW, 5: width of `err_ctrl` / target index.
- NUM_TGT, 25: number of valid targets (0..NUM_TGT-1) addressed by the splitter tree.
- CNTW, 16: width of the delay, length and gap counters.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command (high only in IDLE).
- cmd_sweep  in  1  0 = single target; 1 = sweep cmd_target..cmd_last.
- cmd_target  in  INW  first (or only) target index.
- cmd_last  in  INW  last target index (sweep only; ignored when single).
- cmd_delay  in  CNTW  cycles between accept and first injection.
- cmd_len  in  CNTW  cycles `err_en` is held per target.
- cmd_gap  in  CNTW  idle cycles between sweep windows.
- abort  in  1  terminate the active command.
- err_en  out  1  injection enable to the root splitter.
- err_ctrl  out  INW  target index to the root splitter.
- busy  out  1  command in progress (not IDLE).
- done  out  1  one-cycle pulse when a command completes normally.
- cmd_err  out  1  one-cycle pulse when a command is rejected.

Behaviour:
- Reset: state IDLE; err_en=0, err_ctrl=0, busy=0, done=0, cmd_err=0, cmd_ready=1 in the following cycle. All counters cleared. Reset mid-command drops the command with no done pulse.
- All outputs are registered. err_ctrl is 0 whenever err_en=0.
- Accept event: cmd_valid & cmd_ready at a rising edge (E0). cmd_valid while busy is ignored, not queued.
- Rejection at accept: any of these → cmd_err=1 in cycle E0+1, state stays IDLE, no err_en:
  - cmd_len=0
  - cmd_target ≥ NUM_TGT
  - sweep with cmd_last ≥ NUM_TGT
  - sweep with cmd_last < cmd_target
- The accepted command is latched; inputs may change after E0.
- States:
  - IDLE → DELAY when delay>0; IDLE → INJECT when delay=0.
  - DELAY lasts exactly cmd_delay cycles → INJECT.
  - INJECT lasts exactly cmd_len cycles with err_en=1 and err_ctrl=current target. Then:
    - single, or sweep at cmd_last → DONE.
    - sweep, not last, gap>0 → GAP.
    - sweep, not last, gap=0 → INJECT on the next target immediately. err_en stays high; err_ctrl steps to target+1.
  - GAP lasts exactly cmd_gap cycles with err_en=0 → INJECT on target+1.
  - DONE: one cycle with done=1, busy=0, cmd_ready=1. A new command may be accepted in this cycle; the state is equivalent to IDLE plus the done pulse.
- Timing, single command (cycles numbered after E0): err_en high in cycles D+1..D+L; done in cycle D+L+1.
- Sweep with cmd_target=cmd_last behaves exactly like a single command.
- busy=1 from E0+1 through the last INJECT cycle.
- abort (sampled in any non-IDLE state) → next cycle: err_en=0, err_ctrl=0, state IDLE, no done. Abort in IDLE has no effect. Abort and cmd_valid in the same IDLE cycle: the command is accepted.
- Counters count down from the latched value and terminate at 1; there is no wrap. Max delay/len/gap is 2^CNTW−1.
- Target increment never wraps because cmd_last < NUM_TGT ≤ 2^INW.

Decomposition:
- Shared package `err_inj_pkg`:
  - state enum (IDLE, DELAY, INJECT, GAP, DONE)
  - default INW / NUM_TGT / CNTW constants, shared with the splitter instantiations so the target count stays consistent
  - command struct (sweep, target, last, delay, len, gap)
- One natural sub-module: `err_inj_cnt`, a loadable down-counter with terminal flag, instantiated once and reloaded per phase.

Test Plan:
- Single: target=7, delay=3, len=2 accepted at E0 → err_en=1 & err_ctrl=7 in cycles 4–5 only; done in cycle 6; busy in cycles 1–5.
- Sweep 5..7, delay=0, len=1, gap=1 → err_en pattern 1,0,1,0,1 over cycles 1–5 with err_ctrl 5,0,6,0,7; done in cycle 6. Repeat with gap=0 → err_en high cycles 1–3, err_ctrl 5,6,7.
- Rejects, each → cmd_err in cycle 1, err_en never rises, cmd_ready stays 1:
  - target=25 (NUM_TGT=25)
  - len=0
  - sweep with last=3 < target=4
- Abort during INJECT (target=10, len=8, abort in cycle 3) → err_en=0 from cycle 4; no done; cmd_ready=1 in cycle 4. A new command in that cycle is accepted.
- cmd_valid held high with differing fields during a run → ignored. The next command is accepted exactly in the done cycle, and its first injection starts per its own delay.
- rst asserted mid-DELAY and mid-GAP → next cycle all outputs at reset values; no done or cmd_err.
